prog_delay_gate: RTL and testbench
==================================

// Module: prog_delay_gate
// PURPOSE
//  Parametrised programmable path-delay gate. CH single-bit inputs each pass through a
//  per-channel delay line. Each line's delay is runtime-configurable in clock-enable
//  cycles (0..MAX_DLY). Delayed taps are merged by a selectable logic function into one
//  registered output with a validity flag. Used wherever per-path cycle skew must be
//  modelled/compensated ahead of a combining gate.
// PARAMETERS
//  CH       3   number of input channels (>=2)
//  MAX_DLY  8   maximum delay per channel, in enabled cycles (>=1)
//  DLY_DEF  1   per-channel delay loaded at reset (clamped to MAX_DLY)
//  DW       $clog2(MAX_DLY+1)   delay field width (derived, not overridden)
//  CW       $clog2(CH) (min 1)  channel index width (derived)
// PORTS
//  clk      in   1    clock, all state on rising edge
//  rst_n    in   1    asynchronous active-low reset
//  en       in   1    advance enable; shift/fill/output update only when 1
//  din      in   CH   channel inputs, sampled on en edges
//  mode     in   2    merge: 0 OR-all, 1 AND-all, 2 tap[CH-1] | &tap[CH-2:0], 3 XOR-all
//  cfg_we   in   1    delay config write strobe (independent of en)
//  cfg_ch   in   CW   channel to configure
//  cfg_dly  in   DW   new delay for cfg_ch
//  dout     out  1    registered merged output
//  dout_vld out  1    1 when dout is built only from post-config, post-reset data
// BEHAVIOUR
//  Reset (async, immediate): shift regs=0, dly[i]=min(DLY_DEF,MAX_DLY), fill[i]=0,
//   dout=0, dout_vld=0.
//  Shift: per channel sr[i][0..MAX_DLY-1]; on en edge sr[i][0]<=din[i], sr[i][k]<=sr[i][k-1].
//  Tap (comb): tap[i] = (dly[i]==0) ? din[i] : sr[i][dly[i]-1].
//  Output: on en edge dout<=f(mode,tap); dout_vld<=&(fill[i]>=dly[i]) (pre-edge values).
//   en=0: dout, dout_vld, sr, fill all hold.
//  Latency: din sampled at en edge k appears on dout after en edge k+dly[i]
//   (dly=0 -> same edge). Idle (en=0) cycles do not count.
//  Fill: fill[i] counts en edges since reset/last config of channel i, saturating at MAX_DLY.
//  Config: on cfg_we edge with cfg_ch<CH: dly[cfg_ch]<=min(cfg_dly,MAX_DLY), fill[cfg_ch]<=0.
//   sr contents kept (untrusted). cfg_ch>=CH: write ignored, no state change.
//   New delay used from the next edge.
//  Simultaneous cfg_we & en: shift and dout update use the old dly. fill[cfg_ch] forced to 0
//   (that en edge not counted). Other channels count normally.
//  dout_vld deasserts on the first en edge after a config that raises dly above fill,
//   and reasserts once refilled. Lowering dly never drops dout_vld.
//  mode is sampled with the taps at each en edge. A mode change takes effect on the next
//   en edge, with no effect on dout_vld.
//  Reset mid-operation: all state cleared at once. Post-reset, dout_vld=0 until
//   DLY_DEF en edges have elapsed.
// TESTING
//  1 defaults (CH=3,MAX=8,DEF=1), en=1, mode0, single 1-cycle pulse on din[0] at edge 5
//    -> dout=1 for exactly edge 6 interval; dout_vld=1 from edge 2 on.
//  2 cfg ch0=2, ch1=3, ch2=1, mode2; din[1:0]=11 from edge 20 -> dout rises after edge 23;
//    din[2] pulse at edge 30 (din[1:0]=00) -> dout pulse after edge 31 only.
//  3 en low for 5 cycles mid-stream -> dout/dout_vld frozen; resume gives the same sequence
//    as an ungated run, shifted by 5.
//  4 cfg_dly=15 -> reads back as delay 8 (pulse emerges 8 en edges later);
//    cfg_ch=3 -> no change in behaviour.
//  5 ch1 raised 1->4 with cfg_we & en same edge -> dout_vld low for the next 4 en edges,
//    then high. dly 4->0 -> dout_vld stays high, dout tracks din same edge.
//  6 rst_n pulsed low mid-cycle while data in flight -> dout, dout_vld=0 immediately;
//    old data never reappears on dout.

Source files
------------

// File: rtl/prog_delay_gate.sv
// Programmable per-channel delay lines feeding a mode-selectable merge gate.
// Each channel delays its input by 0..MAX_DLY enabled cycles. The delayed taps
// are combined into one registered output, qualified by a validity flag that
// tracks whether every line has refilled since reset or since its last reconfig.
module prog_delay_gate #(
   parameter int unsigned CH      = 3,
   parameter int unsigned MAX_DLY = 8,
   parameter int unsigned DLY_DEF = 1,
   localparam int unsigned DW     = $clog2(MAX_DLY + 1),
   localparam int unsigned CW     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [CH-1:0] din,
   input  logic [1:0]    mode,
   input  logic          cfg_we,
   input  logic [CW-1:0] cfg_ch,
   input  logic [DW-1:0] cfg_dly,
   output logic          dout,
   output logic          dout_vld
);

   // Reset delay is clamped so an oversized default cannot address past the line.
   localparam int unsigned   DLY_RST   = (DLY_DEF > MAX_DLY) ? MAX_DLY : DLY_DEF;
   localparam logic [DW-1:0] DLY_RST_V = DW'(DLY_RST);
   localparam logic [DW-1:0] MAX_V     = DW'(MAX_DLY);

   localparam logic [1:0] MODE_OR  = 2'd0;
   localparam logic [1:0] MODE_AND = 2'd1;
   localparam logic [1:0] MODE_MIX = 2'd2;
   localparam logic [1:0] MODE_XOR = 2'd3;

   logic [MAX_DLY-1:0] sr_q      [CH];
   logic [MAX_DLY-1:0] sr_nxt_c  [CH];
   logic [DW-1:0]      dly_q     [CH];
   logic [DW-1:0]      fill_q    [CH];
   logic [CH-1:0]      tap_c;
   logic               merged_c;
   logic               vld_c;
   logic               cfg_hit_c;
   logic [DW-1:0]      cfg_val_c;

   // Decode a config write: out-of-range channels are dropped, delay saturates at MAX_DLY.
   always_comb begin
      cfg_hit_c = cfg_we && (32'(cfg_ch) < CH);
      cfg_val_c = (cfg_dly > MAX_V) ? MAX_V : cfg_dly;
   end

   // Next shift-register contents: new sample enters at bit 0, oldest falls off the top.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         sr_nxt_c[i] = MAX_DLY'({sr_q[i], din[i]});
      end
   end

   // Tap select: a zero delay bypasses the line and feeds the live input.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         tap_c[i] = din[i];
         for (int k = 0; k < MAX_DLY; k++) begin
            if (dly_q[i] == DW'(k + 1)) begin
               tap_c[i] = sr_q[i][k];
            end
         end
      end
   end

   // Merge function over the current taps.
   always_comb begin
      merged_c = 1'b0;
      case (mode)
         MODE_OR:  merged_c = |tap_c;
         MODE_AND: merged_c = &tap_c;
         MODE_MIX: merged_c = tap_c[CH-1] | (&tap_c[CH-2:0]);
         MODE_XOR: merged_c = ^tap_c;
         default:  merged_c = 1'b0;
      endcase
   end

   // Output is trustworthy only when every line holds at least dly post-config samples.
   always_comb begin
      vld_c = 1'b1;
      for (int i = 0; i < CH; i++) begin
         if (fill_q[i] < dly_q[i]) begin
            vld_c = 1'b0;
         end
      end
   end

   // Delay lines advance on enabled cycles only; contents survive reconfiguration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            sr_q[i] <= '0;
         end
      end else if (en) begin
         for (int i = 0; i < CH; i++) begin
            sr_q[i] <= sr_nxt_c[i];
         end
      end
   end

   // Per-channel delay and fill counters; a config write restarts that channel's fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            dly_q[i]  <= DLY_RST_V;
            fill_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (cfg_hit_c && (cfg_ch == CW'(i))) begin
               dly_q[i]  <= cfg_val_c;
               fill_q[i] <= '0;
            end else if (en && (fill_q[i] != MAX_V)) begin
               fill_q[i] <= fill_q[i] + DW'(1);
            end
         end
      end
   end

   // Registered merged output and validity, both held while en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout     <= 1'b0;
         dout_vld <= 1'b0;
      end else if (en) begin
         dout     <= merged_c;
         dout_vld <= vld_c;
      end
   end

endmodule

// File: tb/tb_prog_delay_gate.sv
// Directed testbench for prog_delay_gate with default parameters (CH=3, MAX_DLY=8, DLY_DEF=1).
module tb_prog_delay_gate;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [2:0] din;
   logic [1:0] mode;
   logic       cfg_we;
   logic [1:0] cfg_ch;
   logic [3:0] cfg_dly;
   logic       dout;
   logic       dout_vld;

   int checks;
   int failures;

   prog_delay_gate #(.CH(3), .MAX_DLY(8), .DLY_DEF(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .din      (din),
      .mode     (mode),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_dly  (cfg_dly),
      .dout     (dout),
      .dout_vld (dout_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: returns 1 time unit after the rising edge, when outputs are settled.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n   = 1'b0;
      en      = 1'b0;
      din     = 3'b000;
      mode    = 2'd0;
      cfg_we  = 1'b0;
      cfg_ch  = 2'd0;
      cfg_dly = 4'd0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Config write on a cycle with en low.
   task automatic cfg_idle(input logic [1:0] ch, input logic [3:0] d);
      en      = 1'b0;
      cfg_we  = 1'b1;
      cfg_ch  = ch;
      cfg_dly = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      en    = 1'b1;
      din   = 3'b111;
      mode  = 2'd0;
      cfg_we = 1'b0;
      cfg_ch = 2'd0;
      cfg_dly = 4'd0;
      tick();
      tick();
      checks++;
      if (dout !== 1'b0) begin
         failures++;
         $display("FAIL reset_dout got=%b exp=0", dout);
      end
      checks++;
      if (dout_vld !== 1'b0) begin
         failures++;
         $display("FAIL reset_vld got=%b exp=0", dout_vld);
      end
   endtask

   // Single pulse through default delay of 1.
   task automatic test_pulse;
      logic ed, ev;
      do_reset();
      mode = 2'd0;
      en   = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         din = (e == 5) ? 3'b001 : 3'b000;
         tick();
         ed = (e == 6);
         ev = (e >= 2);
         checks++;
         if (dout !== ed) begin
            failures++;
            $display("FAIL pulse_dout edge=%0d got=%b exp=%b", e, dout, ed);
         end
         checks++;
         if (dout_vld !== ev) begin
            failures++;
            $display("FAIL pulse_vld edge=%0d got=%b exp=%b", e, dout_vld, ev);
         end
      end
      din = 3'b000;
   endtask

   // Mode 2 with skewed delays: dout = tap2 | (tap1 & tap0).
   task automatic test_mode2;
      logic ed, ev;
      do_reset();
      cfg_idle(2'd0, 4'd2);
      cfg_idle(2'd1, 4'd3);
      cfg_idle(2'd2, 4'd1);
      mode = 2'd2;
      en   = 1'b1;
      for (int e = 1; e <= 34; e++) begin
         din = 3'b000;
         if (e >= 20 && e <= 24) din[1:0] = 2'b11;
         if (e == 30) din[2] = 1'b1;
         tick();
         ed = (e >= 23 && e <= 26) || (e == 31);
         ev = (e >= 4);
         checks++;
         if (dout !== ed) begin
            failures++;
            $display("FAIL mode2_dout edge=%0d got=%b exp=%b", e, dout, ed);
         end
         checks++;
         if (dout_vld !== ev) begin
            failures++;
            $display("FAIL mode2_vld edge=%0d got=%b exp=%b", e, dout_vld, ev);
         end
      end
      din = 3'b000;
   endtask

   // Enable gating: five idle cycles freeze everything, then the ungated sequence resumes.
   task automatic test_gate;
      logic [2:0] pat [12];
      logic ed, ev, hold_d;
      pat = '{3'b001, 3'b011, 3'b111, 3'b101, 3'b100, 3'b110,
              3'b010, 3'b000, 3'b001, 3'b111, 3'b011, 3'b110};
      do_reset();
      mode   = 2'd3;
      hold_d = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         if (j == 7) begin
            en = 1'b0;
            for (int g = 0; g < 5; g++) begin
               din = 3'($urandom);
               tick();
               checks++;
               if (dout !== hold_d) begin
                  failures++;
                  $display("FAIL gate_hold_dout cyc=%0d got=%b exp=%b", g, dout, hold_d);
               end
               checks++;
               if (dout_vld !== 1'b1) begin
                  failures++;
                  $display("FAIL gate_hold_vld cyc=%0d got=%b exp=1", g, dout_vld);
               end
            end
         end
         en  = 1'b1;
         din = pat[j-1];
         tick();
         ed = (j == 1) ? 1'b0 : ^pat[j-2];
         ev = (j >= 2);
         hold_d = ed;
         checks++;
         if (dout !== ed) begin
            failures++;
            $display("FAIL gate_dout edge=%0d got=%b exp=%b", j, dout, ed);
         end
         checks++;
         if (dout_vld !== ev) begin
            failures++;
            $display("FAIL gate_vld edge=%0d got=%b exp=%b", j, dout_vld, ev);
         end
      end
      din = 3'b000;
   endtask

   // Oversized delay clamps to 8; a write to channel 3 is ignored.
   task automatic test_clamp;
      logic ed, ev;
      do_reset();
      cfg_idle(2'd0, 4'd15);
      mode = 2'd0;
      en   = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         din    = (e == 1 || e == 13) ? 3'b001 : 3'b000;
         cfg_we = (e == 13);
         cfg_ch = 2'd3;
         cfg_dly = 4'd0;
         tick();
         cfg_we = 1'b0;
         ed = (e == 9) || (e == 21);
         ev = (e >= 9);
         checks++;
         if (dout !== ed) begin
            failures++;
            $display("FAIL clamp_dout edge=%0d got=%b exp=%b", e, dout, ed);
         end
         checks++;
         if (dout_vld !== ev) begin
            failures++;
            $display("FAIL clamp_vld edge=%0d got=%b exp=%b", e, dout_vld, ev);
         end
      end
      din = 3'b000;
      cfg_ch = 2'd0;
   endtask

   // Raise ch1 1->4 on an en edge, then drop it 4->0.
   task automatic test_raise_lower;
      logic ed, ev;
      do_reset();
      mode = 2'd0;
      en   = 1'b1;
      for (int e = 1; e <= 18; e++) begin
         din     = 3'b000;
         cfg_we  = (e == 5) || (e == 12);
         cfg_ch  = 2'd1;
         cfg_dly = (e == 5) ? 4'd4 : 4'd0;
         if (e == 14 || e == 16) din[1] = 1'b1;
         tick();
         cfg_we = 1'b0;
         ed = (e == 14) || (e == 16);
         ev = (e >= 2) && !(e >= 6 && e <= 9);
         checks++;
         if (dout !== ed) begin
            failures++;
            $display("FAIL raise_dout edge=%0d got=%b exp=%b", e, dout, ed);
         end
         checks++;
         if (dout_vld !== ev) begin
            failures++;
            $display("FAIL raise_vld edge=%0d got=%b exp=%b", e, dout_vld, ev);
         end
      end
      din = 3'b000;
   endtask

   // Asynchronous reset with data in flight; stale samples must not resurface.
   task automatic test_reset_mid;
      logic ev;
      do_reset();
      cfg_idle(2'd0, 4'd8);
      mode = 2'd0;
      en   = 1'b1;
      din  = 3'b111;
      for (int e = 1; e <= 10; e++) tick();
      checks++;
      if (dout !== 1'b1) begin
         failures++;
         $display("FAIL midrst_pre_dout got=%b exp=1", dout);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dout !== 1'b0) begin
         failures++;
         $display("FAIL midrst_dout got=%b exp=0", dout);
      end
      checks++;
      if (dout_vld !== 1'b0) begin
         failures++;
         $display("FAIL midrst_vld got=%b exp=0", dout_vld);
      end
      tick();
      rst_n = 1'b1;
      din   = 3'b000;
      for (int e = 1; e <= 10; e++) begin
         tick();
         ev = (e >= 2);
         checks++;
         if (dout !== 1'b0) begin
            failures++;
            $display("FAIL midrst_post_dout edge=%0d got=%b exp=0", e, dout);
         end
         checks++;
         if (dout_vld !== ev) begin
            failures++;
            $display("FAIL midrst_post_vld edge=%0d got=%b exp=%b", e, dout_vld, ev);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_pulse();
      test_mode2();
      test_gate();
      test_clamp();
      test_raise_lower();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
